out_reg_bank_ser: RTL and testbench
===================================

// Module: out_reg_bank_ser
// PURPOSE
//  Parametrised multi-channel output register bank for the IO tile, successor to the single-bit output register cell.
//  Each of NCH channels has a configurable-depth registered fabric-to-pad path and a per-channel combinational bypass (OSEL).
//  MODE=1 adds a per-bank parallel-to-serial converter (RATIO:1) with a valid/ready load handshake and gapless back-to-back words.
//  Sits between fabric routing and the IO pad drivers; all outputs drive pad-side F2A nets.
// PARAMETERS
//  NCH         4  number of output channels, legal 1..16
//  PIPE_DEPTH  1  register stages on the registered path, legal 1..4
//  MODE        0  0 = SDR register bank, 1 = serializer feeding the register path
//  RATIO       4  serializer bits per channel per word, legal 2..8 (used only when MODE=1)
// PORTS
//  IQC       in   1           clock, all flops rise on posedge
//  QRT_N     in   1           asynchronous active-low reset
//  CE        in   1           clock enable; gates every register and FSM update
//  OSEL      in   NCH         per-channel bypass: 1 = F2A follows OQI combinationally
//  OQI       in   NCH         per-channel data (registered-path source when MODE=0; bypass source in both modes)
//  PAR_DATA  in   NCH*RATIO   parallel word, channel c in [c*RATIO +: RATIO], LSB sent first
//  LOAD_VLD  in   1           parallel word valid (MODE=1)
//  LOAD_RDY  out  1           bank accepts PAR_DATA this cycle (MODE=1; tied 0 when MODE=0)
//  BUSY      out  1           serializer mid-word (MODE=1; tied 0 when MODE=0)
//  F2A       out  NCH         pad-side outputs
// BEHAVIOUR
//  Reset (QRT_N=0, async assert, sync-to-IQC release by caller): all pipeline stages, shift registers, bit counter = 0;
//   FSM = IDLE; LOAD_RDY = 0, BUSY = 0; F2A[c] = OSEL[c] ? OQI[c] : 0. Bypass mux stays live during reset.
//  F2A[c] = OSEL[c] ? OQI[c] : stage[PIPE_DEPTH-1][c]; OSEL is never registered, switching it glitches only the mux.
//  CE=0: every register and the FSM hold; no handshake transfer occurs.
//  MODE=0: stage0 <= OQI; stage[i] <= stage[i-1]. OQI at edge k appears at F2A after PIPE_DEPTH CE edges.
//  MODE=1: stage0 is the shift-register LSB; stages 1..PIPE_DEPTH-1 follow. OQI feeds only the bypass.
//   Transfer = LOAD_VLD & LOAD_RDY. LOAD_RDY = QRT_N & CE & (state==IDLE | (state==SHIFT & cnt==0)).
//   IDLE: stage0 = 0. On transfer: shreg <= PAR_DATA per channel, cnt <= RATIO-1, -> SHIFT.
//   SHIFT: each CE edge shreg >>= 1, cnt <= cnt-1. At cnt==0: transfer -> reload, cnt <= RATIO-1, stay SHIFT (no gap);
//    no transfer -> IDLE, stage0 <= 0.
//   BUSY = (state==SHIFT). Bit j of a word reaches F2A PIPE_DEPTH-1+j CE edges after its load edge... i.e. bit 0 is
//    visible PIPE_DEPTH edges after the transfer edge, one bit per CE edge thereafter.
//   LOAD_VLD asserted while not ready: held off, PAR_DATA ignored; the caller keeps VLD/data stable until ready.
//  Reset mid-word: word discarded, FSM -> IDLE immediately; no partial bits emitted after release.
//  Counter width = clog2(RATIO); cnt never wraps below 0 (reload or IDLE at 0).
//  Illegal parameters: elaboration-time $error.
// TESTING
//  T1 MODE=0,NCH=4,PIPE_DEPTH=3,OSEL=0: OQI 4'hA at edge 1, 4'h5 at edge 2 -> F2A=4'hA after edge 3, 4'h5 after edge 4.
//  T2 OSEL=4'b0101 during reset with OQI=4'hF -> F2A=4'h5; release, OSEL=0 -> F2A=0 until registered data arrives.
//  T3 MODE=1,RATIO=4,PIPE_DEPTH=1,NCH=1: load 4'b1101 -> F2A 1,0,1,1 on four edges, then 0; LOAD_RDY high on 4th bit.
//  T4 MODE=1 back-to-back: words 4'h3 then 4'hC with LOAD_VLD held -> 8 contiguous bits 1,1,0,0,0,0,1,1, BUSY never drops.
//  T5 CE toggled 1-0-1 mid-word -> bit stream stretched, no bit lost or repeated; LOAD_VLD with CE=0 -> no transfer.
//  T6 QRT_N pulsed low after 2nd bit of 4'hF -> F2A=0 immediately, BUSY=0; after release LOAD_RDY=1 next CE cycle.

Source files
------------

// File: rtl/out_reg_bank_ser.sv
// Multi-channel IO-tile output register bank with per-channel bypass and an
// optional RATIO:1 parallel-to-serial front end feeding the registered path.
module out_reg_bank_ser #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned PIPE_DEPTH = 1,
  parameter int unsigned MODE       = 0,
  parameter int unsigned RATIO      = 4
) (
  input  logic                 IQC,
  input  logic                 QRT_N,
  input  logic                 CE,
  input  logic [NCH-1:0]       OSEL,
  input  logic [NCH-1:0]       OQI,
  input  logic [NCH*RATIO-1:0] PAR_DATA,
  input  logic                 LOAD_VLD,
  output logic                 LOAD_RDY,
  output logic                 BUSY,
  output logic [NCH-1:0]       F2A
);

  localparam int unsigned PW = NCH * RATIO;
  localparam int unsigned TW = (PIPE_DEPTH > 1) ? (PIPE_DEPTH - 1) * NCH : NCH;

  // stage 0 of the registered path, and the stage that reaches the pad mux
  logic [NCH-1:0] head;
  logic [NCH-1:0] last;

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("out_reg_bank_ser: NCH=%0d outside 1..16", NCH);
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("out_reg_bank_ser: PIPE_DEPTH=%0d outside 1..4", PIPE_DEPTH);
  end
  if (MODE > 1) begin : g_bad_mode
    $error("out_reg_bank_ser: MODE=%0d is not 0 or 1", MODE);
  end
  if (MODE == 1 && (RATIO < 2 || RATIO > 8)) begin : g_bad_ratio
    $error("out_reg_bank_ser: RATIO=%0d outside 2..8", RATIO);
  end

  if (MODE == 1) begin : g_ser
    localparam int unsigned CNT_W = $clog2(RATIO);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    shreg_q, shreg_d;
    logic             load_rdy_c;
    logic             xfer_c;

    // ready only when idle or presenting the final bit, so reloads are gapless
    assign load_rdy_c = QRT_N & CE &
                        ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & (cnt_q == '0)));
    assign xfer_c     = LOAD_VLD & load_rdy_c;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      case (state_q)
        ST_IDLE: begin
          if (xfer_c) begin
            shreg_d = PAR_DATA;
            cnt_d   = CNT_W'(RATIO - 1);
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            if (xfer_c) begin
              shreg_d = PAR_DATA;
              cnt_d   = CNT_W'(RATIO - 1);
            end else begin
              shreg_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            for (int c = 0; c < int'(NCH); c++) begin
              shreg_d[c*RATIO +: RATIO] = {1'b0, shreg_q[c*RATIO+1 +: RATIO-1]};
            end
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge IQC or negedge QRT_N) begin
      if (!QRT_N) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        shreg_q <= '0;
      end else if (CE) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        shreg_q <= shreg_d;
      end
    end

    for (genvar c = 0; c < int'(NCH); c++) begin : g_head
      assign head[c] = shreg_q[c*RATIO];
    end

    assign LOAD_RDY = load_rdy_c;
    assign BUSY     = (state_q == ST_SHIFT);
  end else begin : g_sdr
    logic [NCH-1:0] head_q;
    logic           unused_par;

    // parallel-load inputs have no meaning in SDR mode
    assign unused_par = ^{PAR_DATA, LOAD_VLD};

    always_ff @(posedge IQC or negedge QRT_N) begin
      if (!QRT_N) begin
        head_q <= '0;
      end else if (CE) begin
        head_q <= OQI;
      end
    end

    assign head     = head_q;
    assign LOAD_RDY = 1'b0;
    assign BUSY     = 1'b0;
  end

  if (PIPE_DEPTH > 1) begin : g_tail
    logic [TW-1:0]     tail_q;
    logic [TW+NCH-1:0] chain;

    // chain = {stage[PIPE_DEPTH-1] .. stage1, stage0}; one shift per CE edge
    assign chain = {tail_q, head};

    always_ff @(posedge IQC or negedge QRT_N) begin
      if (!QRT_N) begin
        tail_q <= '0;
      end else if (CE) begin
        tail_q <= chain[TW-1:0];
      end
    end

    assign last = chain[TW+NCH-1 -: NCH];
  end else begin : g_no_tail
    assign last = head;
  end

  // pad mux stays live through reset; OSEL is deliberately unregistered
  assign F2A = (OSEL & OQI) | (~OSEL & last);

endmodule

// File: tb/tb_out_reg_bank_ser.sv
// Bench for out_reg_bank_ser: an SDR instance and a serializer instance checked
// every cycle against a queue-based model, plus literal expectations.
module tb_out_reg_bank_ser;

  localparam int unsigned A_NCH = 4;
  localparam int unsigned A_PD  = 3;
  localparam int unsigned B_NCH = 2;
  localparam int unsigned RATIO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  logic [A_NCH-1:0]       a_osel, a_oqi, a_f2a;
  logic [A_NCH*RATIO-1:0] a_par;
  logic                   a_vld, a_rdy, a_busy;

  logic [B_NCH-1:0]       b_osel, b_oqi, b_f2a;
  logic [B_NCH*RATIO-1:0] b_par;
  logic                   b_vld, b_rdy, b_busy;

  int vectors     = 0;
  int miscompares = 0;
  bit auto_oqi    = 1'b0;
  logic [7:0] t4_bits = 8'b1100_0011;

  // model state: OQI samples taken at CE edges, and pending serial symbols
  // (front of sq is the symbol currently on stage 0)
  logic [A_NCH-1:0] hist[$];
  logic [B_NCH-1:0] sq[$];

  out_reg_bank_ser #(.NCH(A_NCH), .PIPE_DEPTH(A_PD), .MODE(0), .RATIO(RATIO)) u_sdr (
    .IQC(clk), .QRT_N(rst_n), .CE(ce), .OSEL(a_osel), .OQI(a_oqi),
    .PAR_DATA(a_par), .LOAD_VLD(a_vld), .LOAD_RDY(a_rdy), .BUSY(a_busy), .F2A(a_f2a)
  );

  out_reg_bank_ser #(.NCH(B_NCH), .PIPE_DEPTH(1), .MODE(1), .RATIO(RATIO)) u_ser (
    .IQC(clk), .QRT_N(rst_n), .CE(ce), .OSEL(b_osel), .OQI(b_oqi),
    .PAR_DATA(b_par), .LOAD_VLD(b_vld), .LOAD_RDY(b_rdy), .BUSY(b_busy), .F2A(b_f2a)
  );

  always #5 clk = ~clk;

  // model: a word accepted at an edge becomes RATIO symbols, one retired per CE edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      sq.delete();
    end else if (ce) begin
      hist.push_back(a_oqi);
      if (hist.size() > int'(A_PD)) void'(hist.pop_front());
      if (b_vld && sq.size() <= 1) begin
        if (sq.size() > 0) void'(sq.pop_front());
        for (int j = 0; j < int'(RATIO); j++) sq.push_back({b_par[RATIO+j], b_par[j]});
      end else if (sq.size() > 0) begin
        void'(sq.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [A_NCH-1:0] a_last;
    logic [B_NCH-1:0] b_head;
    a_last = (hist.size() == int'(A_PD)) ? hist[0] : '0;
    b_head = (sq.size() > 0) ? sq[0] : '0;
    check("sdr_f2a", 8'(a_f2a), 8'((a_osel & a_oqi) | (~a_osel & a_last)));
    check("sdr_rdy_tied", 8'(a_rdy), 8'h00);
    check("sdr_busy_tied", 8'(a_busy), 8'h00);
    check("ser_f2a", 8'(b_f2a), 8'((b_osel & b_oqi) | (~b_osel & b_head)));
    check("ser_busy", 8'(b_busy), 8'(sq.size() > 0));
    check("ser_rdy", 8'(b_rdy), 8'(rst_n & ce & (sq.size() <= 1)));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    if (auto_oqi) begin
      a_oqi  = a_oqi + 4'd3;
      a_osel = {3'b000, a_oqi[3]};
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1;
    a_osel = 4'b0101; a_oqi = 4'hF; a_par = '0; a_vld = 1'b0;
    b_osel = '0; b_oqi = '0; b_par = '0; b_vld = 1'b0;

    // T2: bypass live during reset, zero registered path after release
    #1;
    check("t2_bypass_in_reset", 8'(a_f2a), 8'h05);
    check("t2_ser_rdy_in_reset", 8'(b_rdy), 8'h00);
    cycle();
    rst_n = 1'b1; a_osel = '0;
    #1;
    check("t2_released_no_data", 8'(a_f2a), 8'h00);
    cycle();
    check("t2_one_edge", 8'(a_f2a), 8'h00);

    // T1: three-stage SDR latency
    a_oqi = 4'hA; cycle();
    a_oqi = 4'h5; cycle();
    check("t1_first_sample", 8'(a_f2a), 8'h0F);
    a_oqi = 4'h0; cycle();
    check("t1_a_after_3", 8'(a_f2a), 8'h0A);
    cycle();
    check("t1_5_after_3", 8'(a_f2a), 8'h05);
    cycle();
    check("t1_zero", 8'(a_f2a), 8'h00);
    auto_oqi = 1'b1;

    // T3: ch0 1101, ch1 0110
    b_par = 8'h6D; b_vld = 1'b1;
    #1;
    check("t3_rdy_idle", 8'(b_rdy), 8'h01);
    cycle(); b_vld = 1'b0;
    check("t3_bit0", 8'(b_f2a), 8'h01);
    check("t3_busy", 8'(b_busy), 8'h01);
    check("t3_rdy_mid", 8'(b_rdy), 8'h00);
    cycle(); check("t3_bit1", 8'(b_f2a), 8'h02);
    cycle(); check("t3_bit2", 8'(b_f2a), 8'h03);
    cycle(); check("t3_bit3", 8'(b_f2a), 8'h01);
    check("t3_rdy_last", 8'(b_rdy), 8'h01);
    cycle(); check("t3_idle_f2a", 8'(b_f2a), 8'h00);
    check("t3_idle_busy", 8'(b_busy), 8'h00);

    // T4: 3 then C back to back on both channels
    b_par = 8'h33; b_vld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("t4_bit", 8'(b_f2a), 8'({2{t4_bits[k]}}));
      check("t4_busy", 8'(b_busy), 8'h01);
      if (k == 0) b_par = 8'hCC;
      if (k == 4) b_vld = 1'b0;
    end
    cycle();
    check("t4_end_f2a", 8'(b_f2a), 8'h00);
    check("t4_end_busy", 8'(b_busy), 8'h00);

    // T5: CE stall mid-word, then VLD with CE low while idle
    b_par = 8'h59; b_vld = 1'b1;
    cycle(); b_vld = 1'b0;
    check("t5_bit0", 8'(b_f2a), 8'h03);
    cycle(); check("t5_bit1", 8'(b_f2a), 8'h00);
    ce = 1'b0; b_vld = 1'b1; b_par = 8'hFF;
    cycle(); check("t5_hold", 8'(b_f2a), 8'h00);
    check("t5_hold_rdy", 8'(b_rdy), 8'h00);
    cycle(); check("t5_hold2_busy", 8'(b_busy), 8'h01);
    ce = 1'b1; b_vld = 1'b0; b_par = 8'h00;
    cycle(); check("t5_bit2", 8'(b_f2a), 8'h02);
    cycle(); check("t5_bit3", 8'(b_f2a), 8'h01);
    cycle(); check("t5_idle", 8'(b_f2a), 8'h00);
    ce = 1'b0; b_vld = 1'b1; b_par = 8'hFF;
    cycle(); check("t5_ce0_no_xfer", 8'(b_busy), 8'h00);
    ce = 1'b1; b_vld = 1'b0;
    cycle(); check("t5_ce0_still_idle", 8'(b_busy), 8'h00);
    check("t5_ce0_f2a", 8'(b_f2a), 8'h00);

    // T6: reset after the second bit of ch0 F, ch1 A
    b_par = 8'hAF; b_vld = 1'b1;
    cycle(); b_vld = 1'b0;
    check("t6_bit0", 8'(b_f2a), 8'h01);
    cycle(); check("t6_bit1", 8'(b_f2a), 8'h03);
    rst_n = 1'b0;
    #1;
    check("t6_rst_f2a", 8'(b_f2a), 8'h00);
    check("t6_rst_busy", 8'(b_busy), 8'h00);
    check("t6_rst_rdy", 8'(b_rdy), 8'h00);
    cycle();
    rst_n = 1'b1;
    #1;
    check("t6_rdy_after_release", 8'(b_rdy), 8'h01);
    cycle(); check("t6_no_partial", 8'(b_f2a), 8'h00);
    check("t6_idle_busy", 8'(b_busy), 8'h00);

    // serializer bypass
    b_osel = 2'b10; b_oqi = 2'b11;
    #1;
    check("ser_bypass_hi", 8'(b_f2a), 8'h02);
    b_oqi = 2'b01;
    #1;
    check("ser_bypass_lo", 8'(b_f2a), 8'h00);
    cycle();
    b_osel = '0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
